mem_access: RTL
===============

# mem_access

Memory-stage access controller for the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register. Converts the MEM-stage load/store controls into a req/ack transaction on the data-memory port. Stalls the pipeline while the transaction is in flight, then presents the aligned, extended load result as `MEM_Data_in` to the MEM/WB register.

## Interface
Parameters:
- `ADDR_W`, 32, width of the byte address and of `dmem_addr`

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `MEM_MemRead`  in  1  load in the MEM stage
- `MEM_MemWrite`  in  1  store in the MEM stage
- `MEM_Size`  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- `MEM_Unsigned`  in  1  zero-extend a load (1) or sign-extend it (0)
- `MEM_ALU`  in  ADDR_W  effective byte address
- `MEM_Store_Data`  in  32  store data, right-aligned
- `dmem_req`  out  1  transaction request, registered
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  ADDR_W  word address, low 2 bits always 0
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_rdata`  in  32  read data, valid with `dmem_ack`
- `dmem_ack`  in  1  completes the transaction
- `mem_stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; the top level also forces the MEM/WB RegWrite input to 0 while it is high
- `MEM_Data_in`  out  32  extended load result to MEM/WB
- `mem_exc`  out  1  misaligned-access pulse (`MISALIGN_TRAP_EN` only; otherwise tied 0)

## Operation
States: IDLE, REQ, DONE.
- **IDLE**
  - If `MEM_MemWrite` or `MEM_MemRead` is high: `mem_stall`=1 (combinational), latch the address, size, unsigned flag and computed enables/data, then go to REQ.
  - Otherwise `mem_stall`=0.
  - If both controls are high, the access is a write and the read is ignored.
- **REQ**
  - `dmem_req`=1 and `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` are held stable until `dmem_ack`; `mem_stall`=1.
  - On `dmem_ack`: `dmem_req` drops next cycle; for a read, the extended result is registered into `MEM_Data_in`; go to DONE.
- **DONE**
  - `mem_stall`=0, so the pipeline advances and MEM/WB captures `MEM_Data_in` at the end of this cycle.
  - Next state is IDLE, which evaluates the next MEM instruction.
- Store lanes, with off = `MEM_ALU[1:0]`:
  - byte: `dmem_be` = 1<<off, data replicated into all 4 lanes
  - half: `dmem_be` = 0011 (off[1]=0) or 1100 (off[1]=1), data replicated into both halves
  - word: `dmem_be` = 1111
- Load extract: byte lane off, half lane off[1], word as-is; then sign- or zero-extend to 32 bits.
- `dmem_addr` = {`MEM_ALU`[ADDR_W-1:2], 2'b00}.
- `MEM_Data_in` holds its value between loads; a store leaves it unchanged.

## Timing
- Reset values: state IDLE, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_be`=0, `dmem_wdata`=0, `MEM_Data_in`=0, `mem_exc`=0. `mem_stall` is 0 after reset because it is combinational from IDLE with no access.
- Minimum access: IDLE (stall) → REQ with ack in the same cycle (stall) → DONE. That is 2 stall cycles; each extra ack-wait cycle adds 1.
- Load data is visible on `MEM_Data_in` in DONE and is in WB one cycle later.
- `dmem_ack` while in IDLE or DONE is ignored.
- Reset asserted mid-REQ: `dmem_req` drops immediately and the access is abandoned; the memory side must tolerate this.
- Non-memory instructions never stall.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A half access with `MEM_ALU[0]`=1, or a word access with `MEM_ALU[1:0]`≠0, issues no request.
  - IDLE goes straight to DONE with `mem_stall`=1 for that one IDLE cycle.
  - `mem_exc`=1 for the DONE cycle only.
  - `MEM_Data_in`=0.
- Undefined: the low address bits are ignored for alignment (half uses off[1], word uses the full word) and the access proceeds normally; `mem_exc` is constant 0.

## Test plan
- Reset: `rst_n`=0 with `dmem_ack`=1 → all outputs 0, no request issued.
- Word load: `MEM_ALU`=0x104, ack in the first REQ cycle, `dmem_rdata`=0xDEADBEEF → `dmem_addr`=0x104, `dmem_be`=1111, 2 stall cycles, `MEM_Data_in`=0xDEADBEEF in DONE.
- Byte load: off=3, `dmem_rdata`=0x80112233 → signed 0xFFFFFF80; unsigned 0x00000080.
- Half store: `MEM_ALU`=0x202, data 0x0000ABCD, ack delayed 3 cycles → `dmem_be`=1100, `dmem_wdata`=0xABCDABCD, stall high for 5 cycles, outputs stable throughout REQ.
- Reset mid-REQ → `dmem_req` low asynchronously, state IDLE, a following load completes normally.
- Misaligned word load at 0x101 → with the macro: no `dmem_req`, `mem_exc` pulses for 1 cycle, `MEM_Data_in`=0; without it: `dmem_addr`=0x100, normal load.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store controller.
// Turns the MEM-stage load/store controls into one req/ack transaction on the
// data-memory port, stalls the pipeline while it is in flight and returns the
// aligned, sign/zero-extended load result on MEM_Data_in.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no request, one-cycle mem_exc pulse, MEM_Data_in cleared).
//
// state | meaning
// IDLE  | evaluate the MEM instruction; stall if it accesses memory
// REQ   | request on the bus, held stable until dmem_ack
// DONE  | pipeline released; MEM/WB captures MEM_Data_in
module mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [1:0]        MEM_Size,
  input  logic              MEM_Unsigned,
  input  logic [ADDR_W-1:0] MEM_ALU,
  input  logic [31:0]       MEM_Store_Data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic [31:0]       MEM_Data_in,
  output logic              mem_exc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_off;
  logic [31:0]       r_data_in;

  logic              w_access;
  logic [1:0]        w_off;
  logic              w_misalign;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  assign w_access = MEM_MemRead | MEM_MemWrite;
  assign w_off    = MEM_ALU[1:0];

`ifdef MISALIGN_TRAP_EN
  logic r_exc;

  assign w_misalign = ((MEM_Size == 2'b01) && w_off[0]) ||
                      (MEM_Size[1] && (w_off != 2'b00));
  assign mem_exc    = r_exc;

  // Trap pulse: raised for the DONE cycle that follows a trapped IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc <= 1'b0;
    end else begin
      r_exc <= (r_state == S_IDLE) && w_access && w_misalign;
    end
  end
`else
  // Low address bits are ignored for alignment; accesses always proceed.
  assign w_misalign = 1'b0;
  assign mem_exc    = 1'b0;
`endif

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = MEM_Store_Data;
    case (MEM_Size)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{MEM_Store_Data[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{MEM_Store_Data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = MEM_Store_Data;
      end
    endcase
  end

  // Load lane extraction and extension from the latched size/offset.
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_off)
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  // State register; the request is registered so it follows entry into REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == S_REQ);
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_next = w_misalign ? S_DONE : S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ:   w_next = dmem_ack ? S_DONE : S_REQ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stall while an access is being accepted or is in flight.
  always_comb begin
    mem_stall = 1'b0;
    case (r_state)
      S_IDLE:  mem_stall = w_access;
      S_REQ:   mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Capture the access in IDLE and the load result on ack; a write wins over a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_off      <= 2'd0;
      r_data_in  <= 32'd0;
    end else begin
      if ((r_state == S_IDLE) && w_access) begin
        if (w_misalign) begin
          r_data_in <= 32'd0;
        end else begin
          r_we       <= MEM_MemWrite;
          r_addr     <= {MEM_ALU[ADDR_W-1:2], 2'b00};
          r_be       <= w_be;
          r_wdata    <= w_wdata;
          r_size     <= MEM_Size;
          r_unsigned <= MEM_Unsigned;
          r_off      <= w_off;
        end
      end
      if ((r_state == S_REQ) && dmem_ack && !r_we) begin
        r_data_in <= w_load;
      end
    end
  end

  assign dmem_req    = r_req;
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_be     = r_be;
  assign dmem_wdata  = r_wdata;
  assign MEM_Data_in = r_data_in;

endmodule
